ta_chunk_sequencer: RTL and testbench

Fetch-side driver for the clause comparison pipeline. On `start`, walks every clause and every literal chunk in clause-major order, reads the TA-state word and the matching input chunk from fixed-latency RAMs, and presents one (ta_state, xin, clause_id, la_chunk_id) beat per cycle to the comparator stage, using `stop_flag` as the per-cycle hold. Ends each run with one flush beat so downstream accumulators register the final clause. Sits between the TA/feature memories and the CMP stage.

---
 rtl/ta_chunk_sequencer_pkg.sv | 39 +++
 rtl/seq_skid_fifo.sv | 47 ++++
 rtl/ta_chunk_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_ta_chunk_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ta_chunk_sequencer_pkg.sv
// ta_chunk_sequencer_pkg: shared types and constants for the chunk sequencer.
//   seq_state_e  - sequencer FSM states
//   SkidDepth    - skid FIFO depth, which also bounds the reads that may be outstanding
//   TagW         - width of the clause / chunk beat tags
//   beat_t       - one comparator beat {ta_state, xin, clause_id, la_chunk_id}
//   flush_beat() - builds the end-of-run marker beat (clause_id == CLAUSES)
package ta_chunk_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StFlush,
    StDone
  } seq_state_e;

  localparam int unsigned SkidDepth = 4;
  localparam int unsigned SkidPtrW  = $clog2(SkidDepth);
  localparam int unsigned SkidCntW  = $clog2(SkidDepth + 1);
  localparam int unsigned TagW      = 17;
  localparam int unsigned DataW     = 32;
  localparam int unsigned BeatW     = 2 * DataW + 2 * TagW;

  typedef struct packed {
    logic [DataW-1:0] ta_state;
    logic [DataW-1:0] xin;
    logic [TagW-1:0]  clause_id;
    logic [TagW-1:0]  la_chunk_id;
  } beat_t;

  // Downstream recognises the end of a run by a clause id one past the last clause.
  function automatic beat_t flush_beat(input int unsigned clauses);
    beat_t b;
    b           = '0;
    b.clause_id = clauses[TagW-1:0];
    return b;
  endfunction

endpackage

// File: rtl/seq_skid_fifo.sv
// seq_skid_fifo: 4-entry skid FIFO holding beats returned from the RAMs.
//   clk, rst_flag_n - clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data - write one beat; the caller never pushes when full
//   pop,  pop_data  - pop_data is the head entry; pop only when count != 0
//   count           - current occupancy 0..4
module seq_skid_fifo
  import ta_chunk_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_flag_n,
  input  logic                push,
  input  logic [BeatW-1:0]    push_data,
  input  logic                pop,
  output logic [BeatW-1:0]    pop_data,
  output logic [SkidCntW-1:0] count
);

  logic [BeatW-1:0]    mem_q [SkidDepth];
  logic [SkidPtrW-1:0] wr_ptr_q;
  logic [SkidPtrW-1:0] rd_ptr_q;
  logic [SkidCntW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + SkidPtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + SkidPtrW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + SkidCntW'(1);
        2'b01:   count_q <= count_q - SkidCntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/ta_chunk_sequencer.sv
// ta_chunk_sequencer: walks every (clause, chunk) pair in clause-major order, reads the TA word
// and the input chunk from fixed-latency RAMs and presents one beat per cycle to the comparator,
// ending each run with a flush beat (clause_id == CLAUSES).
//   clk, rst_flag_n         - clock, asynchronous active-low reset
//   start                   - one-cycle run request, accepted only when idle
//   hold                    - downstream backpressure, no beat while high
//   busy, done              - run in progress / one-cycle end-of-run pulse
//   ta_rd_en, ta_addr       - TA RAM read (address = clause*LA_CHUNKS + chunk)
//   ta_rdata                - TA word, valid MEM_LATENCY cycles after the strobe
//   x_rd_en, x_addr, x_rdata- input-buffer read, issued together with the TA read
//   ta_state, xin           - beat data
//   clause_id, la_chunk_id  - beat tags
//   stop_flag               - low exactly on cycles carrying a beat
// Optional: define TM_SEQ_PERF_CNT_EN to add beat_cnt / hold_cnt performance counters.
module ta_chunk_sequencer
  import ta_chunk_sequencer_pkg::*;
#(
  parameter int unsigned CLAUSES     = 2000,
  parameter int unsigned LA_CHUNKS   = 49,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned AW          = $clog2(CLAUSES * LA_CHUNKS),
  parameter int unsigned XW          = $clog2(LA_CHUNKS)
) (
  input  logic            clk,
  input  logic            rst_flag_n,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            ta_rd_en,
  output logic [AW-1:0]   ta_addr,
  input  logic [31:0]     ta_rdata,
  output logic            x_rd_en,
  output logic [XW-1:0]   x_addr,
  input  logic [31:0]     x_rdata,
  output logic [31:0]     ta_state,
  output logic [31:0]     xin,
  output logic [TagW-1:0] clause_id,
  output logic [TagW-1:0] la_chunk_id,
  output logic            stop_flag
`ifdef TM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]     beat_cnt,
  output logic [31:0]     hold_cnt
`endif
);

  localparam logic [TagW-1:0] LastClause = TagW'(CLAUSES - 1);
  localparam logic [TagW-1:0] LastChunk  = TagW'(LA_CHUNKS - 1);

  seq_state_e state_q, state_d;
  logic [TagW-1:0] clause_q, clause_d;
  logic [TagW-1:0] chunk_q, chunk_d;
  logic [AW-1:0]   addr_q, addr_d;

  // In-flight read tracker, one stage per cycle of RAM latency.
  logic            pipe_vld_q    [MEM_LATENCY];
  logic [TagW-1:0] pipe_clause_q [MEM_LATENCY];
  logic [TagW-1:0] pipe_chunk_q  [MEM_LATENCY];

  logic [SkidCntW-1:0] inflight;
  logic [SkidCntW-1:0] fifo_count;
  logic [SkidCntW:0]   occupancy;
  logic                issue;
  logic                push;
  logic                pop;
  logic                flush_go;
  logic                present;
  logic [BeatW-1:0]    fifo_rdata;
  beat_t               push_beat;
  beat_t               head_beat;
  beat_t               beat_cur;
  beat_t               out_q;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(MEM_LATENCY); i++) begin
      inflight = inflight + {{(SkidCntW-1){1'b0}}, pipe_vld_q[i]};
    end
  end

  // A slot popped this cycle is free for a read issued this cycle, so the credit count nets out
  // the pop; without that a 3-cycle RAM could not sustain one beat per cycle.
  assign pop       = !hold && (fifo_count != '0);
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count} - {{SkidCntW{1'b0}}, pop};
  assign issue     = (state_q == StIssue) && (occupancy < (SkidCntW+1)'(SkidDepth));
  assign push      = pipe_vld_q[MEM_LATENCY-1];
  assign push_beat = {ta_rdata, x_rdata, pipe_clause_q[MEM_LATENCY-1],
                      pipe_chunk_q[MEM_LATENCY-1]};
  assign head_beat = beat_t'(fifo_rdata);
  assign flush_go  = (state_q == StFlush) && !hold;
  assign present   = pop || flush_go;

  always_comb begin
    state_d  = state_q;
    clause_d = clause_q;
    chunk_d  = chunk_q;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          clause_d = '0;
          chunk_d  = '0;
          addr_d   = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d = addr_q + AW'(1);
          if (chunk_q == LastChunk) begin
            chunk_d  = '0;
            clause_d = clause_q + TagW'(1);
            if (clause_q == LastClause) state_d = StDrain;
          end else begin
            chunk_d = chunk_q + TagW'(1);
          end
        end
      end
      StDrain: begin
        // Leave as soon as the last beat is popped so the flush beat follows with no gap.
        if (occupancy == '0) state_d = StFlush;
      end
      StFlush: begin
        if (!hold) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      state_q  <= StIdle;
      clause_q <= '0;
      chunk_q  <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      clause_q <= clause_d;
      chunk_q  <= chunk_d;
      addr_q   <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        pipe_vld_q[i]    <= 1'b0;
        pipe_clause_q[i] <= '0;
        pipe_chunk_q[i]  <= '0;
      end
    end else begin
      pipe_vld_q[0]    <= issue;
      pipe_clause_q[0] <= clause_q;
      pipe_chunk_q[0]  <= chunk_q;
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        pipe_vld_q[i]    <= pipe_vld_q[i-1];
        pipe_clause_q[i] <= pipe_clause_q[i-1];
        pipe_chunk_q[i]  <= pipe_chunk_q[i-1];
      end
    end
  end

  seq_skid_fifo u_skid (
    .clk        (clk),
    .rst_flag_n (rst_flag_n),
    .push       (push),
    .push_data  (push_beat),
    .pop        (pop),
    .pop_data   (fifo_rdata),
    .count      (fifo_count)
  );

  // Beat outputs follow the popped entry on a beat cycle and otherwise repeat the last beat.
  always_comb begin
    beat_cur = out_q;
    if (flush_go) begin
      beat_cur = flush_beat(CLAUSES);
    end else if (pop) begin
      beat_cur = head_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      out_q <= '0;
    end else begin
      out_q <= beat_cur;
    end
  end

  assign busy        = (state_q == StIssue) || (state_q == StDrain) || (state_q == StFlush);
  assign done        = (state_q == StDone);
  assign ta_rd_en    = issue;
  assign x_rd_en     = issue;
  assign ta_addr     = addr_q;
  assign x_addr      = chunk_q[XW-1:0];
  assign ta_state    = beat_cur.ta_state;
  assign xin         = beat_cur.xin;
  assign clause_id   = beat_cur.clause_id;
  assign la_chunk_id = beat_cur.la_chunk_id;
  assign stop_flag   = !present;

`ifdef TM_SEQ_PERF_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] hold_cnt_q;

  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      beat_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      beat_cnt_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      if (present)     beat_cnt_q <= beat_cnt_q + 32'd1;
      if (busy && hold) hold_cnt_q <= hold_cnt_q + 32'd1;
    end
  end

  assign beat_cnt = beat_cnt_q;
  assign hold_cnt = hold_cnt_q;
`endif

endmodule

// File: tb/tb_ta_chunk_sequencer.sv
// Bench for ta_chunk_sequencer: two instances (RAM latency 2 and 3) share start/hold/reset and
// are checked against a reference beat list built directly from the clause/chunk walk order.
module tb_ta_chunk_sequencer;

  localparam int CL = 3;
  localparam int LA = 2;
  localparam int N  = CL * LA;
  localparam int NB = N + 1;
  localparam int AW = $clog2(CL * LA);
  localparam int XW = $clog2(LA);

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic hold;

  logic          busy_w [2];
  logic          done_w [2];
  logic          ta_rd_en_w [2];
  logic          x_rd_en_w [2];
  logic          stop_w [2];
  logic [AW-1:0] ta_addr_w [2];
  logic [XW-1:0] x_addr_w [2];
  logic [31:0]   ta_rdata_w [2];
  logic [31:0]   x_rdata_w [2];
  logic [31:0]   ta_state_w [2];
  logic [31:0]   xin_w [2];
  logic [16:0]   clause_w [2];
  logic [16:0]   chunk_w [2];
`ifdef TM_SEQ_PERF_CNT_EN
  logic [31:0]   beat_cnt_w [2];
  logic [31:0]   hold_cnt_w [2];
`endif

  always #5 clk = ~clk;

  ta_chunk_sequencer #(.CLAUSES(CL), .LA_CHUNKS(LA), .MEM_LATENCY(2)) u_dut_l2 (
    .clk (clk), .rst_flag_n (rst_n), .start (start), .hold (hold),
    .busy (busy_w[0]), .done (done_w[0]),
    .ta_rd_en (ta_rd_en_w[0]), .ta_addr (ta_addr_w[0]), .ta_rdata (ta_rdata_w[0]),
    .x_rd_en (x_rd_en_w[0]), .x_addr (x_addr_w[0]), .x_rdata (x_rdata_w[0]),
    .ta_state (ta_state_w[0]), .xin (xin_w[0]),
    .clause_id (clause_w[0]), .la_chunk_id (chunk_w[0]), .stop_flag (stop_w[0])
`ifdef TM_SEQ_PERF_CNT_EN
    , .beat_cnt (beat_cnt_w[0]), .hold_cnt (hold_cnt_w[0])
`endif
  );

  ta_chunk_sequencer #(.CLAUSES(CL), .LA_CHUNKS(LA), .MEM_LATENCY(3)) u_dut_l3 (
    .clk (clk), .rst_flag_n (rst_n), .start (start), .hold (hold),
    .busy (busy_w[1]), .done (done_w[1]),
    .ta_rd_en (ta_rd_en_w[1]), .ta_addr (ta_addr_w[1]), .ta_rdata (ta_rdata_w[1]),
    .x_rd_en (x_rd_en_w[1]), .x_addr (x_addr_w[1]), .x_rdata (x_rdata_w[1]),
    .ta_state (ta_state_w[1]), .xin (xin_w[1]),
    .clause_id (clause_w[1]), .la_chunk_id (chunk_w[1]), .stop_flag (stop_w[1])
`ifdef TM_SEQ_PERF_CNT_EN
    , .beat_cnt (beat_cnt_w[1]), .hold_cnt (hold_cnt_w[1])
`endif
  );

  // RAM models: contents sampled on the strobe edge, visible `latency` cycles after the strobe.
  // Cycles without a strobe return a poison word.
  logic [31:0] ta_mem [8];
  logic [31:0] x_mem [2];
  logic [31:0] ta_pipe [2][3];
  logic [31:0] x_pipe [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ta_pipe[d][0] <= ta_rd_en_w[d] ? ta_mem[ta_addr_w[d]] : 32'hdead_beef;
      x_pipe[d][0]  <= x_rd_en_w[d] ? x_mem[x_addr_w[d]] : 32'hbad0_bad0;
      for (int s = 1; s < 3; s++) begin
        ta_pipe[d][s] <= ta_pipe[d][s-1];
        x_pipe[d][s]  <= x_pipe[d][s-1];
      end
    end
  end

  assign ta_rdata_w[0] = ta_pipe[0][1];
  assign x_rdata_w[0]  = x_pipe[0][1];
  assign ta_rdata_w[1] = ta_pipe[1][2];
  assign x_rdata_w[1]  = x_pipe[1][2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-run observations, one slot per DUT.
  int            nbeats [2];
  int            naddr [2];
  int            n_data [2];
  int            max_out [2];
  int            done_cnt [2];
  int            busy_at_done [2];
  int            hold_viol [2];
  int            pair_err [2];
  int            stable_err [2];
  int            first_beat [2];
  int            flush_cyc [2];
  int            done_cyc [2];
  logic          busy_c0 [2];
  logic          busy_c1 [2];
  logic          have_prev [2];
  logic [97:0]   prev [2];
  logic [97:0]   beats [2][16];
  logic [AW-1:0] addrs [2][16];
  logic [XW-1:0] xaddrs [2][16];

  task automatic clear_run();
    for (int d = 0; d < 2; d++) begin
      nbeats[d] = 0; naddr[d] = 0; n_data[d] = 0; max_out[d] = 0;
      done_cnt[d] = 0; busy_at_done[d] = 0; hold_viol[d] = 0; pair_err[d] = 0;
      stable_err[d] = 0; first_beat[d] = -1; flush_cyc[d] = -1; done_cyc[d] = -1;
      busy_c0[d] = 1'bx; busy_c1[d] = 1'bx; have_prev[d] = 1'b0; prev[d] = '0;
      for (int i = 0; i < 16; i++) begin
        beats[d][i] = '0; addrs[d][i] = '0; xaddrs[d][i] = '0;
      end
    end
    for (int i = 0; i < 8; i++) ta_mem[i] = $urandom;
    for (int i = 0; i < 2; i++) x_mem[i] = $urandom;
  endtask

  // Reference: beat i of a run is chunk (i mod LA) of clause (i div LA); the flush beat follows.
  function automatic logic [97:0] exp_beat(input int i);
    int c;
    int k;
    if (i == N) return {32'd0, 32'd0, 17'(CL), 17'd0};
    c = i / LA;
    k = i % LA;
    return {ta_mem[c * LA + k], x_mem[k], 17'(c), 17'(k)};
  endfunction

  function automatic logic hold_for(input int mode, input int cyc);
    case (mode)
      1:       return (cyc >= 5) && (cyc <= 9);
      2:       return (cyc % 2) == 1;
      3:       return $urandom_range(0, 99) < 40;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] outs_vec(input int d);
    return {busy_w[d], done_w[d], ta_rd_en_w[d], x_rd_en_w[d], ta_addr_w[d], x_addr_w[d],
            ta_state_w[d], xin_w[d], clause_w[d], chunk_w[d], stop_w[d]};
  endfunction

  task automatic sample(input int cyc);
    logic [97:0] cur;
    for (int d = 0; d < 2; d++) begin
      cur = {ta_state_w[d], xin_w[d], clause_w[d], chunk_w[d]};
      if (cyc == 0) busy_c0[d] = busy_w[d];
      if (cyc == 1) busy_c1[d] = busy_w[d];
      if (x_rd_en_w[d] !== ta_rd_en_w[d]) pair_err[d]++;
      if (ta_rd_en_w[d] === 1'b1) begin
        if (naddr[d] < 16) begin
          addrs[d][naddr[d]]  = ta_addr_w[d];
          xaddrs[d][naddr[d]] = x_addr_w[d];
        end
        naddr[d]++;
      end
      if (stop_w[d] === 1'b0) begin
        if (nbeats[d] < 16) beats[d][nbeats[d]] = cur;
        nbeats[d]++;
        if (first_beat[d] < 0) first_beat[d] = cyc;
        if (clause_w[d] == 17'(CL)) flush_cyc[d] = cyc;
        else n_data[d]++;
        if (hold) hold_viol[d]++;
        prev[d]      = cur;
        have_prev[d] = 1'b1;
      end else if (have_prev[d] && (cur !== prev[d])) begin
        stable_err[d]++;
      end
      if (naddr[d] - n_data[d] > max_out[d]) max_out[d] = naddr[d] - n_data[d];
      if (done_w[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
        if (busy_w[d] !== 1'b0) busy_at_done[d]++;
      end
    end
  endtask

  task automatic verify(input int mode, input string name);
    int lat;
    for (int d = 0; d < 2; d++) begin
      lat = d + 2;
      check_eq($sformatf("%s_l%0d_done_pulses", name, lat), 128'(done_cnt[d]), 128'd1);
      check_eq($sformatf("%s_l%0d_busy_at_done", name, lat), 128'(busy_at_done[d]), 128'd0);
      check_eq($sformatf("%s_l%0d_beat_count", name, lat), 128'(nbeats[d]), 128'(NB));
      for (int i = 0; i < NB; i++) begin
        check_eq($sformatf("%s_l%0d_beat%0d", name, lat, i), 128'(beats[d][i]),
                 128'(exp_beat(i)));
      end
      check_eq($sformatf("%s_l%0d_read_count", name, lat), 128'(naddr[d]), 128'(N));
      for (int i = 0; i < N; i++) begin
        check_eq($sformatf("%s_l%0d_addr%0d", name, lat, i),
                 128'({addrs[d][i], xaddrs[d][i]}), 128'({AW'(i), XW'(i % LA)}));
      end
      check_eq($sformatf("%s_l%0d_beat_under_hold", name, lat), 128'(hold_viol[d]), 128'd0);
      check_eq($sformatf("%s_l%0d_outstanding_over4", name, lat), 128'(max_out[d] > 4),
               128'd0);
      check_eq($sformatf("%s_l%0d_strobe_pair", name, lat), 128'(pair_err[d]), 128'd0);
      check_eq($sformatf("%s_l%0d_held_outputs", name, lat), 128'(stable_err[d]), 128'd0);
      if (mode == 0) begin
        check_eq($sformatf("%s_l%0d_busy_c0", name, lat), 128'(busy_c0[d]), 128'd0);
        check_eq($sformatf("%s_l%0d_busy_c1", name, lat), 128'(busy_c1[d]), 128'd1);
        check_eq($sformatf("%s_l%0d_first_beat_cyc", name, lat), 128'(first_beat[d]),
                 128'(2 + lat));
        check_eq($sformatf("%s_l%0d_flush_cyc", name, lat), 128'(flush_cyc[d]),
                 128'(N + 2 + lat));
        check_eq($sformatf("%s_l%0d_done_cyc", name, lat), 128'(done_cyc[d]),
                 128'(N + 3 + lat));
      end
    end
  endtask

  // One run: start at cycle 0, hold pattern per mode, optional extra start at restart_at.
  // Bounded at 300 cycles; a run that never finishes shows up as a done-count failure.
  task automatic run(input int mode, input int restart_at, input string name);
    int cyc;
    int last;
    clear_run();
    @(posedge clk); #1;
    start = 1'b1;
    hold  = 1'b0;
    @(negedge clk);
    sample(0);
    cyc  = 1;
    last = -1;
    while ((cyc < 300) && ((last < 0) || (cyc <= last + 3))) begin
      @(posedge clk); #1;
      start = (cyc == restart_at);
      hold  = hold_for(mode, cyc);
      @(negedge clk);
      sample(cyc);
      if ((done_cnt[0] > 0) && (done_cnt[1] > 0) && (last < 0)) last = cyc;
      cyc++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    hold  = 1'b0;
    verify(mode, name);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    clear_run();
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) check_eq($sformatf("reset_l%0d", d + 2), outs_vec(d), 128'd1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run(0, -1, "nohold");
    run(1, -1, "holdwin");
`ifdef TM_SEQ_PERF_CNT_EN
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("perf_beat_cnt_l%0d", d + 2), 128'(beat_cnt_w[d]), 128'd7);
      check_eq($sformatf("perf_hold_cnt_l%0d", d + 2), 128'(hold_cnt_w[d]), 128'd5);
    end
`endif
    run(2, -1, "toggle");
    run(0, 3, "restart");
    run(2, 6, "restart_toggle");
    for (int r = 0; r < 4; r++) run(3, -1, $sformatf("rand%0d", r));

    // Reset while draining (last read issued at cycle 6, flush not before cycle 10).
    clear_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    sample(0);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      sample(cyc);
    end
    check_eq("pre_reset_reads_l2", 128'(naddr[0]), 128'(N));
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("drain_reset_l%0d", d + 2), outs_vec(d), 128'd1);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run(0, -1, "after_reset");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
